// File: rtl/cmp_share_sched.sv
// -----------------------------------------------------------------------------
// cmp_share_sched
//   Shares one unsigned magnitude comparator between NUM_REQ requesters.
//   A round-robin arbiter accepts one (A, B) pair at a time. The pair is
//   latched, then compared. The one-hot lt/eq/gt result is returned with the
//   owning requester id on a single valid/ready response port.
//
//   Optional feature: define CMP_SHARE_STATS_EN to add saturating 16-bit
//   per-outcome response counters (stat_lt / stat_eq / stat_gt).
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   req_valid  in   [NUM_REQ]        per-requester request valid
//   req_ready  out  [NUM_REQ]        per-requester accept (one-hot or zero)
//   req_a      in   [NUM_REQ*WIDTH]  packed A operands, slice i*WIDTH +: WIDTH
//   req_b      in   [NUM_REQ*WIDTH]  packed B operands, same packing
//   rsp_valid  out  result valid
//   rsp_ready  in   downstream accepts result
//   rsp_id     out  [ID_W] requester that owns the result
//   rsp_lt     out  A < B
//   rsp_eq     out  A == B
//   rsp_gt     out  A > B
//   stat_lt/eq/gt  out [16]  response counters (CMP_SHARE_STATS_EN only)
//
// FSM states
//   state  | meaning
//   IDLE   | arbitrate; grant and latch operands of the winning requester
//   CMP    | compare latched operands, load result registers
//   RESP   | hold result until the response handshake
// -----------------------------------------------------------------------------
module cmp_share_sched #(
    parameter int  NUM_REQ = 4,
    parameter int  WIDTH   = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic                     rsp_lt,
    output logic                     rsp_eq,
    output logic                     rsp_gt
`ifdef CMP_SHARE_STATS_EN
    ,
    output logic [15:0]              stat_lt,
    output logic [15:0]              stat_eq,
    output logic [15:0]              stat_gt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic              rsp_lt_q, rsp_lt_d;
    logic              rsp_eq_q, rsp_eq_d;
    logic              rsp_gt_q, rsp_gt_d;

    logic              gnt_found;
    logic [ID_W-1:0]   gnt_id;
    logic [ID_W:0]     scan;

    // Search upward from rr_ptr with wrap; the extra bit keeps the sum from
    // overflowing before the wrap correction for non-power-of-two NUM_REQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        scan      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
            if (scan >= (ID_W+1)'(NUM_REQ)) begin
                scan = scan - (ID_W+1)'(NUM_REQ);
            end
            if (!gnt_found && req_valid[scan[ID_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_id    = scan[ID_W-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_lt_d    = rsp_lt_q;
        rsp_eq_d    = rsp_eq_q;
        rsp_gt_d    = rsp_gt_q;
        req_ready   = '0;

        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    req_ready[gnt_id] = 1'b1;
                    a_d     = req_a[gnt_id*WIDTH +: WIDTH];
                    b_d     = req_b[gnt_id*WIDTH +: WIDTH];
                    id_d    = gnt_id;
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                rsp_lt_d    = (a_q <  b_q);
                rsp_eq_d    = (a_q == b_q);
                rsp_gt_d    = (a_q >  b_q);
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rr_ptr_d    = (rsp_id_q == ID_W'(NUM_REQ-1)) ? '0 : rsp_id_q + ID_W'(1);
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // No accept while in reset: the grant would be discarded by the reset.
        if (rst) begin
            req_ready = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_lt_q    <= 1'b0;
            rsp_eq_q    <= 1'b0;
            rsp_gt_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_lt_q    <= rsp_lt_d;
            rsp_eq_q    <= rsp_eq_d;
            rsp_gt_q    <= rsp_gt_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_lt    = rsp_lt_q;
    assign rsp_eq    = rsp_eq_q;
    assign rsp_gt    = rsp_gt_q;

`ifdef CMP_SHARE_STATS_EN
    logic [15:0] stat_lt_q;
    logic [15:0] stat_eq_q;
    logic [15:0] stat_gt_q;
    logic        rsp_fire;

    assign rsp_fire = rsp_valid_q && rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_lt_q <= '0;
            stat_eq_q <= '0;
            stat_gt_q <= '0;
        end else if (rsp_fire) begin
            if (rsp_lt_q && (stat_lt_q != 16'hFFFF)) stat_lt_q <= stat_lt_q + 16'd1;
            if (rsp_eq_q && (stat_eq_q != 16'hFFFF)) stat_eq_q <= stat_eq_q + 16'd1;
            if (rsp_gt_q && (stat_gt_q != 16'hFFFF)) stat_gt_q <= stat_gt_q + 16'd1;
        end
    end

    assign stat_lt = stat_lt_q;
    assign stat_eq = stat_eq_q;
    assign stat_gt = stat_gt_q;
`endif

endmodule

// File: tb/tb_cmp_share_sched.sv
module tb_cmp_share_sched;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic        rsp_lt, rsp_eq, rsp_gt;

    logic [1:0]  v8;
    logic [1:0]  r8;
    logic [15:0] a8;
    logic [15:0] b8;
    logic        rv8;
    logic        rr8;
    logic [0:0]  id8;
    logic        lt8, eq8, gt8;

`ifdef CMP_SHARE_STATS_EN
    logic [15:0] stat_lt, stat_eq, stat_gt;
    logic [15:0] s8_lt, s8_eq, s8_gt;
`endif

    int errors = 0;
    int checks = 0;

    cmp_share_sched #(.NUM_REQ(4), .WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_lt    (rsp_lt),
        .rsp_eq    (rsp_eq),
        .rsp_gt    (rsp_gt)
`ifdef CMP_SHARE_STATS_EN
        ,
        .stat_lt   (stat_lt),
        .stat_eq   (stat_eq),
        .stat_gt   (stat_gt)
`endif
    );

    cmp_share_sched #(.NUM_REQ(2), .WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (v8),
        .req_ready (r8),
        .req_a     (a8),
        .req_b     (b8),
        .rsp_valid (rv8),
        .rsp_ready (rr8),
        .rsp_id    (id8),
        .rsp_lt    (lt8),
        .rsp_eq    (eq8),
        .rsp_gt    (gt8)
`ifdef CMP_SHARE_STATS_EN
        ,
        .stat_lt   (s8_lt),
        .stat_eq   (s8_eq),
        .stat_gt   (s8_gt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns at a falling edge with rst just released; DUT is in IDLE, rr_ptr=0.
    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        v8        = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Drive-only transaction for requester id (used for counter stimulus).
    task automatic drive_txn(input int id, input logic [3:0] a, input logic [3:0] b);
        req_valid        = 4'(1 << id);
        req_a[id*4 +: 4] = a;
        req_b[id*4 +: 4] = b;
        rsp_ready        = 1'b1;
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        v8        = 2'b11;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready_in_rst: got %b expected 0000", req_ready); end
        repeat (2) @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id: got %0d expected 0", rsp_id); end
        checks++; if ({rsp_lt, rsp_eq, rsp_gt} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {rsp_lt, rsp_eq, rsp_gt}); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready_held: got %b expected 0000", req_ready); end
        checks++; if (r8 !== 2'b00) begin errors++; $display("FAIL reset_ready_w8: got %b expected 00", r8); end
        rst       = 1'b0;
        req_valid = '0;
        v8        = '0;
    endtask

    task automatic test_single();
        req_valid = 4'b0001;
        req_a     = 16'h0008;
        req_b     = 16'h0009;
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b expected 0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_ready_pulse: got %b expected 0000", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_latency_early: got %b expected 0", rsp_valid); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid: got %b expected 1", rsp_valid); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL single_rsp_id: got %0d expected 0", rsp_id); end
        checks++; if ({rsp_lt, rsp_eq, rsp_gt} !== 3'b100) begin errors++; $display("FAIL single_flags: got %b expected 100", {rsp_lt, rsp_eq, rsp_gt}); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_drop: got %b expected 0", rsp_valid); end
        checks++; if (rsp_lt !== 1'b1) begin errors++; $display("FAIL single_lt_retained: got %b expected 1", rsp_lt); end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_f [4];
        logic [3:0] exp_rdy;
        exp_f = '{3'b010, 3'b001, 3'b100, 3'b010};   // {lt,eq,gt} for ids 0..3
        do_reset();
        req_a     = {4'd15, 4'd2,  4'd7, 4'd10};
        req_b     = {4'd15, 4'd14, 4'd6, 4'd10};
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp_rdy = 4'(1 << (k % 4));
            #1;
            checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", k, req_ready, exp_rdy); end
            @(negedge clk);
            checks++; if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rr_cmp[%0d]: got ready=%b valid=%b expected 0000/0", k, req_ready, rsp_valid); end
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(k % 4)) begin errors++; $display("FAIL rr_rsp[%0d]: got valid=%b id=%0d expected 1/%0d", k, rsp_valid, rsp_id, k % 4); end
            checks++; if ({rsp_lt, rsp_eq, rsp_gt} !== exp_f[k % 4]) begin errors++; $display("FAIL rr_flags[%0d]: got %b expected %b", k, {rsp_lt, rsp_eq, rsp_gt}, exp_f[k % 4]); end
            @(negedge clk);
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        // rr_ptr is 0 here; id0/id1 not valid so search must skip to id2.
        req_valid      = 4'b0100;
        req_a[11:8]    = 4'd12;
        req_b[11:8]    = 4'd3;
        req_a[3:0]     = 4'd0;
        req_b[3:0]     = 4'd0;
        rsp_ready      = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_grant: got %b expected 0100", req_ready); end
        @(negedge clk);
        req_valid = 4'b0001;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || {rsp_lt, rsp_eq, rsp_gt} !== 3'b001) begin
                errors++; $display("FAIL bp_hold[%0d]: got valid=%b id=%0d flags=%b expected 1/2/001", k, rsp_valid, rsp_id, {rsp_lt, rsp_eq, rsp_gt});
            end
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_no_accept[%0d]: got %b expected 0000", k, req_ready); end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        // rr_ptr now 3; only id0 valid, so the search must wrap to 0.
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got %b expected 0", rsp_valid); end
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_wrap_grant: got %b expected 0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        checks++; if (rsp_id !== 2'd0 || {rsp_lt, rsp_eq, rsp_gt} !== 3'b010) begin errors++; $display("FAIL bound_0_0: got id=%0d flags=%b expected 0/010", rsp_id, {rsp_lt, rsp_eq, rsp_gt}); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        // rr_ptr is 1 here.
        req_valid   = 4'b0010;
        req_a[7:4]  = 4'd0;
        req_b[7:4]  = 4'd15;
        rsp_ready   = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rst_mid_grant: got %b expected 0010", req_ready); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_lt !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: got valid=%b id=%0d lt=%b expected 1/1/1", rsp_valid, rsp_id, rsp_lt); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || {rsp_lt, rsp_eq, rsp_gt} !== 3'b000) begin
            errors++; $display("FAIL rst_mid_clear: got valid=%b id=%0d flags=%b expected 0/0/000", rsp_valid, rsp_id, {rsp_lt, rsp_eq, rsp_gt});
        end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_mid_ready: got %b expected 0000", req_ready); end
        rst       = 1'b0;
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rst_mid_regrant: got %b expected 0010", req_ready); end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || {rsp_lt, rsp_eq, rsp_gt} !== 3'b100) begin
            errors++; $display("FAIL bound_0_15: got valid=%b id=%0d flags=%b expected 1/1/100", rsp_valid, rsp_id, {rsp_lt, rsp_eq, rsp_gt});
        end
        @(negedge clk);
    endtask

    task automatic test_boundary();
        // rr_ptr is 2 here.
        req_valid   = 4'b0100;
        req_a[11:8] = 4'd15;
        req_b[11:8] = 4'd0;
        rsp_ready   = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bound_grant: got %b expected 0100", req_ready); end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || {rsp_lt, rsp_eq, rsp_gt} !== 3'b001) begin
            errors++; $display("FAIL bound_15_0: got valid=%b id=%0d flags=%b expected 1/2/001", rsp_valid, rsp_id, {rsp_lt, rsp_eq, rsp_gt});
        end
        @(negedge clk);
    endtask

    task automatic test_width8();
        rr8 = 1'b1;
        v8  = 2'b01;
        a8  = 16'h00FF;
        b8  = 16'h00FE;
        #1;
        checks++; if (r8 !== 2'b01) begin errors++; $display("FAIL w8_grant0: got %b expected 01", r8); end
        @(negedge clk);
        v8 = '0;
        @(negedge clk);
        checks++; if (rv8 !== 1'b1 || id8 !== 1'b0 || {lt8, eq8, gt8} !== 3'b001) begin
            errors++; $display("FAIL w8_255_254: got valid=%b id=%0d flags=%b expected 1/0/001", rv8, id8, {lt8, eq8, gt8});
        end
        @(negedge clk);
        v8 = 2'b10;
        a8 = 16'hFE00;
        b8 = 16'hFF00;
        #1;
        checks++; if (r8 !== 2'b10) begin errors++; $display("FAIL w8_grant1: got %b expected 10", r8); end
        @(negedge clk);
        v8 = '0;
        @(negedge clk);
        checks++; if (rv8 !== 1'b1 || id8 !== 1'b1 || {lt8, eq8, gt8} !== 3'b100) begin
            errors++; $display("FAIL w8_254_255: got valid=%b id=%0d flags=%b expected 1/1/100", rv8, id8, {lt8, eq8, gt8});
        end
        @(negedge clk);
    endtask

`ifdef CMP_SHARE_STATS_EN
    task automatic test_stats();
        do_reset();
        checks++; if ({stat_lt, stat_eq, stat_gt} !== 48'd0) begin errors++; $display("FAIL stats_reset: got %h expected 0", {stat_lt, stat_eq, stat_gt}); end
        drive_txn(0, 4'd1, 4'd2);
        drive_txn(0, 4'd0, 4'd9);
        drive_txn(0, 4'd7, 4'd8);
        drive_txn(0, 4'd3, 4'd3);
        drive_txn(0, 4'd6, 4'd6);
        drive_txn(0, 4'd5, 4'd4);
        checks++; if (stat_lt !== 16'd3) begin errors++; $display("FAIL stats_lt: got %0d expected 3", stat_lt); end
        checks++; if (stat_eq !== 16'd2) begin errors++; $display("FAIL stats_eq: got %0d expected 2", stat_eq); end
        checks++; if (stat_gt !== 16'd1) begin errors++; $display("FAIL stats_gt: got %0d expected 1", stat_gt); end
        for (int k = 0; k < 65536; k++) drive_txn(0, 4'd0, 4'd0);
        checks++; if (stat_eq !== 16'hFFFF) begin errors++; $display("FAIL stats_eq_sat: got %h expected ffff", stat_eq); end
        checks++; if (stat_lt !== 16'd3) begin errors++; $display("FAIL stats_lt_after: got %0d expected 3", stat_lt); end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        v8        = '0;
        a8        = '0;
        b8        = '0;
        rr8       = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_reset_mid_op();
        test_boundary();
        test_width8();
`ifdef CMP_SHARE_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
